// File: rtl/alu_cmd_ctrl_if.sv
// alu_cmd_ctrl_if: groups the byte-link streams, the ALU command/result bus
// and the status outputs of the ALU command front-end.
//   rx_data/rx_valid/rx_ready : inbound command byte stream
//   tx_data/tx_valid/tx_ready : outbound result byte stream
//   alu_en/alu_fun/alu_a/alu_b: ALU command, alu_out/alu_out_valid: ALU result
//   busy/frame_err/timeout_err/frame_cnt : status
// master: the controller view. slave: the surrounding link and ALU.
interface alu_cmd_ctrl_if;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned OPND_W = 16;
  localparam int unsigned FUN_W  = 4;

  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [BYTE_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              alu_en;
  logic [FUN_W-1:0]  alu_fun;
  logic [OPND_W-1:0] alu_a;
  logic [OPND_W-1:0] alu_b;
  logic [OPND_W-1:0] alu_out;
  logic              alu_out_valid;
  logic              busy;
  logic              frame_err;
  logic              timeout_err;
  logic [BYTE_W-1:0] frame_cnt;

  modport master (
    input  rx_data, rx_valid, tx_ready, alu_out, alu_out_valid,
    output rx_ready, tx_data, tx_valid, alu_en, alu_fun, alu_a, alu_b,
           busy, frame_err, timeout_err, frame_cnt
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, alu_out, alu_out_valid,
    input  rx_ready, tx_data, tx_valid, alu_en, alu_fun, alu_a, alu_b,
           busy, frame_err, timeout_err, frame_cnt
  );
endinterface

// File: rtl/alu_cmd_ctrl.sv
// alu_cmd_ctrl: receives a 5-byte command frame (header, A lo, A hi, B lo,
// B hi), issues one ALU operation, waits for the registered ALU result and
// returns it as two bytes, low byte first.
// Ports:
//   clk         : system clock, rising edge
//   rst         : synchronous active-low reset
//   bus.master  : byte streams, ALU bus and status (see alu_cmd_ctrl_if)
// Parameter:
//   TIMEOUT_CYC : WAIT cycles without alu_out_valid before the frame is aborted
module alu_cmd_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 4
) (
  input  logic           clk,
  input  logic           rst,
  alu_cmd_ctrl_if.master bus
);

  localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned OPND_W = 16;
  localparam int unsigned FUN_W  = 4;
  localparam logic [3:0]  SYNC   = 4'hA;

  typedef enum logic [3:0] {
    S_IDLE, S_A_LO, S_A_HI, S_B_LO, S_B_HI,
    S_ISSUE, S_WAIT, S_TX_LO, S_TX_HI
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [FUN_W-1:0]  fun_q;
  logic [OPND_W-1:0] a_q;
  logic [OPND_W-1:0] b_q;
  logic [OPND_W-1:0] result_q;
  logic [BYTE_W-1:0] frame_cnt_q;
  logic [CNT_W-1:0]  wait_cnt;
  logic              frame_err_q;
  logic              timeout_err_q;

  logic rx_open;
  logic rx_fire;
  logic tx_fire;
  logic hdr_ok;
  logic timeout_hit;

  // Handshake qualifiers; rx_open depends on the state register only.
  assign rx_open     = (state inside {S_IDLE, S_A_LO, S_A_HI, S_B_LO, S_B_HI});
  assign rx_fire     = rx_open && bus.rx_valid;
  assign tx_fire     = (state inside {S_TX_LO, S_TX_HI}) && bus.tx_ready;
  assign hdr_ok      = (bus.rx_data[7:4] == SYNC);
  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYC));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (rx_fire && hdr_ok) state_nxt = S_A_LO;
      S_A_LO:  if (rx_fire) state_nxt = S_A_HI;
      S_A_HI:  if (rx_fire) state_nxt = S_B_LO;
      S_B_LO:  if (rx_fire) state_nxt = S_B_HI;
      S_B_HI:  if (rx_fire) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (bus.alu_out_valid) state_nxt = S_TX_LO;
        else if (timeout_hit)  state_nxt = S_IDLE;
      end
      S_TX_LO: if (tx_fire) state_nxt = S_TX_HI;
      S_TX_HI: if (tx_fire) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, wait counter, result register, error pulses, frame count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fun_q         <= '0;
      a_q           <= '0;
      b_q           <= '0;
      result_q      <= '0;
      frame_cnt_q   <= '0;
      wait_cnt      <= '0;
      frame_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      frame_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rx_fire) begin
            if (hdr_ok) fun_q       <= bus.rx_data[3:0];
            else        frame_err_q <= 1'b1;
          end
        end
        S_A_LO:  if (rx_fire) a_q[7:0]  <= bus.rx_data;
        S_A_HI:  if (rx_fire) a_q[15:8] <= bus.rx_data;
        S_B_LO:  if (rx_fire) b_q[7:0]  <= bus.rx_data;
        S_B_HI:  if (rx_fire) b_q[15:8] <= bus.rx_data;
        S_ISSUE: wait_cnt <= '0;
        S_WAIT: begin
          if (bus.alu_out_valid) result_q      <= bus.alu_out;
          else if (timeout_hit)  timeout_err_q <= 1'b1;
          else                   wait_cnt      <= wait_cnt + CNT_W'(1);
        end
        S_TX_HI: if (tx_fire) frame_cnt_q <= frame_cnt_q + BYTE_W'(1);
        default: ;
      endcase
    end
  end

  // Output decode: strobes come from the state register, data from registers.
  always_comb begin
    bus.rx_ready    = rx_open;
    bus.busy        = (state != S_IDLE);
    bus.alu_en      = (state == S_ISSUE);
    bus.tx_valid    = (state inside {S_TX_LO, S_TX_HI});
    bus.tx_data     = '0;
    bus.alu_fun     = fun_q;
    bus.alu_a       = a_q;
    bus.alu_b       = b_q;
    bus.frame_err   = frame_err_q;
    bus.timeout_err = timeout_err_q;
    bus.frame_cnt   = frame_cnt_q;
    if (state == S_TX_LO)      bus.tx_data = result_q[7:0];
    else if (state == S_TX_HI) bus.tx_data = result_q[15:8];
  end

endmodule
